systolic_array_stream: RTL and testbench
========================================

Name: systolic_array_stream

Overview:
- Parametrised ROWS x COLS output-stationary systolic MAC array with built-in input skewing, a run controller and a backpressured drain port.
- Each input beat carries one ifm value per row and one weight per column. After K beats, every PE(r,c) holds the sum over k of ifm[r][k]*wgt[c][k].
- Results are streamed out one column per beat.
- Sits between the ifm/weight buffers and the ofm write-back path. It replaces the fixed 16x16 array, which needs an external skew and drain sequencer.

Parameters:
- DATA_WIDTH, 8, width of each ifm/weight element.
- ACC_WIDTH, 20, accumulator and output element width.
- ROWS, 16, PE rows (ifm lanes, output lanes).
- COLS, 16, PE columns (weight lanes, drain beats).
- K_WIDTH, 8, width of k_len.
- SIGNED, 1, 1 = two's-complement multiply, 0 = unsigned.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a run; sampled only in IDLE.
- k_len, input, K_WIDTH, number of input beats; latched with start.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, array accepts a beat.
- ifm_in, input, ROWS*DATA_WIDTH, row r at [r*DATA_WIDTH +: DATA_WIDTH].
- wgt_in, input, COLS*DATA_WIDTH, column c at [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid, output, 1, drain beat valid.
- out_ready, input, 1, consumer accepts a drain beat.
- ofm_out, output, ROWS*ACC_WIDTH, lane r = acc of PE(r, beat index).
- out_last, output, 1, high on the final drain beat.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse after the last drain beat.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-run:
  - state returns to IDLE; all accumulators, skew registers, PE pipeline registers and counters clear to 0.
  - in_ready, out_valid, out_last, busy and done go to 0; ofm_out goes to 0.
  - Any run in progress is abandoned; no done pulse is produced.
- The FSM has four states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - in_ready=0.
  - start=1 with k_len!=0: latch k_len, go to LOAD.
  - start with k_len=0 is ignored (stay in IDLE, no done).
- LOAD:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Array enable = accepted beat. With no beat, all skew/PE registers hold (full stall), so results are independent of in_valid gaps.
  - After the k_len-th accepted beat, go to FLUSH.
- FLUSH:
  - in_ready=0. The array is enabled every cycle with zero operands injected.
  - Lasts exactly ROWS+COLS-1 cycles, then go to DRAIN.
- Skewing:
  - ifm row r passes through r delay registers; wgt column c passes through c delay registers. Delay registers advance only when the array is enabled.
  - ifm moves right and wgt moves down one PE per enabled cycle, so operands of beat k meet at PE(r,c) r+c enabled cycles after acceptance.
- MAC:
  - acc += ifm*wgt on each enabled cycle.
  - The product is 2*DATA_WIDTH bits, signed or unsigned per SIGNED, then sign/zero-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
- DRAIN:
  - out_valid=1. ofm_out lane r = acc(r, c), where c = drain index, starting at 0.
  - Index advances only on out_valid && out_ready. ofm_out and out_last are held stable while out_ready=0.
  - out_last=1 when c=COLS-1.
  - On acceptance of the last beat: accumulators clear to 0, done=1 for the next cycle, state returns to IDLE.
- start outside IDLE is ignored.
- ofm_out equals 0 when out_valid=0.
- Minimum run time: k_len + ROWS + COLS - 1 + COLS cycles, plus 1 for done.

Test Plan (ROWS=COLS=4, DATA_WIDTH=8, ACC_WIDTH=20, SIGNED=1 unless stated):
1. k_len=3, all ifm=1, all wgt=2, in_valid and out_ready held high -> 4 drain beats, each ofm_out lane=6, out_last on beat 4, done pulse 1 cycle later, busy falls with return to IDLE.
2. k_len=2, ifm lanes=0xFD (-3), wgt=5 -> every lane 0xFFFE2 (-30). Repeat with SIGNED=0 -> 253*5*2 = 2530 = 0x009E2.
3. Scenario 1 with in_valid low 2 cycles between beats -> identical outputs; in_ready stays 1 throughout LOAD.
4. ifm row r = r+1, wgt col c = c+1, k_len=1 -> drain beat c lane r = (r+1)*(c+1). Exercises the skew. out_ready low for 5 cycles at drain start -> beat 0 held stable with out_valid=1.
5. k_len=66, ifm=wgt=127 -> 66*16129 = 1064514 mod 2^20 = 15938 = 0x03E42 on all lanes (wrap check).
6. rst asserted mid-LOAD -> next cycle all outputs 0, state IDLE, no done. start pulse during DRAIN is ignored. start with k_len=0 in IDLE -> busy stays 0.

Source files
------------

// File: rtl/systolic_array_stream.sv
// Output-stationary ROWS x COLS MAC array with built-in operand skewing, a run
// controller (IDLE/LOAD/FLUSH/DRAIN) and a backpressured column-by-column drain port.
module systolic_array_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int K_WIDTH    = 8,
    parameter int SIGNED     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] ifm_in,
    input  logic [COLS*DATA_WIDTH-1:0] wgt_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROWS*ACC_WIDTH-1:0]  ofm_out,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW        = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [K_WIDTH-1:0] k_len_reg, k_len_next;
    logic [K_WIDTH-1:0] k_cnt_reg, k_cnt_next;
    logic [FW-1:0]      flush_cnt_reg, flush_cnt_next;
    logic [CW-1:0]      drain_cnt_reg, drain_cnt_next;
    logic               done_reg, done_next;

    logic beat_acc;
    logic array_en;
    logic drain_acc;
    logic drain_last;
    logic acc_clr;

    // Operand buses between PEs: a_in moves right along a row, b_in moves down a column.
    logic [DATA_WIDTH-1:0] a_in    [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_in    [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  acc_val [ROWS][COLS];

    assign beat_acc   = (state_reg == LOAD) && in_valid;
    assign array_en   = beat_acc || (state_reg == FLUSH);
    assign drain_acc  = (state_reg == DRAIN) && out_ready;
    assign drain_last = (drain_cnt_reg == CW'(COLS - 1));
    assign acc_clr    = drain_acc && drain_last;

    // ------------------------------------------------------------------
    // Run controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            k_len_reg     <= '0;
            k_cnt_reg     <= '0;
            flush_cnt_reg <= '0;
            drain_cnt_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            k_len_reg     <= k_len_next;
            k_cnt_reg     <= k_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        k_len_next     = k_len_reg;
        k_cnt_next     = k_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && (k_len != '0)) begin
                    k_len_next = k_len;
                    k_cnt_next = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (beat_acc) begin
                    if (k_cnt_reg == k_len_reg - K_WIDTH'(1)) begin
                        k_cnt_next     = '0;
                        flush_cnt_next = '0;
                        state_next     = FLUSH;
                    end else begin
                        k_cnt_next = k_cnt_reg + K_WIDTH'(1);
                    end
                end
            end
            FLUSH: begin
                // Long enough for the last beat to reach the far corner PE.
                if (flush_cnt_reg == FW'(FLUSH_LEN - 1)) begin
                    flush_cnt_next = '0;
                    drain_cnt_next = '0;
                    state_next     = DRAIN;
                end else begin
                    flush_cnt_next = flush_cnt_reg + FW'(1);
                end
            end
            DRAIN: begin
                if (drain_acc) begin
                    if (drain_last) begin
                        drain_cnt_next = '0;
                        done_next      = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == DRAIN);
    assign out_last  = (state_reg == DRAIN) && drain_last;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

    // ------------------------------------------------------------------
    // Input skew: row r is delayed r enabled cycles, column c delayed c.
    // Operands are forced to zero outside accepted beats so FLUSH injects zeros.
    // ------------------------------------------------------------------
    genvar gi, gj;

    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_ifm_skew
            logic [DATA_WIDTH-1:0] lane;
            assign lane = beat_acc ? ifm_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (gi == 0) begin : g_direct
                assign a_in[gi][0] = lane;
            end else begin : g_delay
                logic [DATA_WIDTH-1:0] dly_reg [gi];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int i = 0; i < gi; i++) dly_reg[i] <= '0;
                    end else if (array_en) begin
                        dly_reg[0] <= lane;
                        for (int i = 1; i < gi; i++) dly_reg[i] <= dly_reg[i-1];
                    end
                end
                assign a_in[gi][0] = dly_reg[gi-1];
            end
        end

        for (gj = 0; gj < COLS; gj++) begin : g_wgt_skew
            logic [DATA_WIDTH-1:0] lane;
            assign lane = beat_acc ? wgt_in[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (gj == 0) begin : g_direct
                assign b_in[0][gj] = lane;
            end else begin : g_delay
                logic [DATA_WIDTH-1:0] dly_reg [gj];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int i = 0; i < gj; i++) dly_reg[i] <= '0;
                    end else if (array_en) begin
                        dly_reg[0] <= lane;
                        for (int i = 1; i < gj; i++) dly_reg[i] <= dly_reg[i-1];
                    end
                end
                assign b_in[0][gj] = dly_reg[gj-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                logic [ACC_WIDTH-1:0] acc_reg;
                logic [ACC_WIDTH-1:0] prod_ext;

                if (SIGNED != 0) begin : g_smul
                    logic signed [PW-1:0] prod;
                    assign prod     = PW'($signed(a_in[gi][gj])) * PW'($signed(b_in[gi][gj]));
                    assign prod_ext = ACC_WIDTH'(prod);
                end else begin : g_umul
                    logic [PW-1:0] prod;
                    assign prod     = PW'(a_in[gi][gj]) * PW'(b_in[gi][gj]);
                    assign prod_ext = ACC_WIDTH'(prod);
                end

                // Accumulation wraps; the clear on the final drain beat readies the next run.
                always_ff @(posedge clk) begin
                    if (rst || acc_clr) begin
                        acc_reg <= '0;
                    end else if (array_en) begin
                        acc_reg <= acc_reg + prod_ext;
                    end
                end
                assign acc_val[gi][gj] = acc_reg;

                if (gj < COLS - 1) begin : g_pass_right
                    logic [DATA_WIDTH-1:0] a_reg;
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            a_reg <= '0;
                        end else if (array_en) begin
                            a_reg <= a_in[gi][gj];
                        end
                    end
                    assign a_in[gi][gj+1] = a_reg;
                end

                if (gi < ROWS - 1) begin : g_pass_down
                    logic [DATA_WIDTH-1:0] b_reg;
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            b_reg <= '0;
                        end else if (array_en) begin
                            b_reg <= b_in[gi][gj];
                        end
                    end
                    assign b_in[gi+1][gj] = b_reg;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Drain mux: lane r shows column drain_cnt_reg, zero when not draining.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_drain
            assign ofm_out[gi*ACC_WIDTH +: ACC_WIDTH] =
                (state_reg == DRAIN) ? acc_val[gi][drain_cnt_reg] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array_stream.sv
// Self-checking bench for systolic_array_stream (4x4): table-driven runs, hand-written
// corner sequences and randomized runs checked against a plain dot-product model.
module tb_systolic_array_stream;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, in_valid, out_ready;
    logic [KW-1:0]   k_len;
    logic [R*DW-1:0] ifm_in;
    logic [C*DW-1:0] wgt_in;
    logic            in_ready, out_valid, out_last, busy, done;
    logic [R*AW-1:0] ofm_out;
    logic            in_ready_u, out_valid_u, out_last_u, busy_u, done_u;
    logic [R*AW-1:0] ofm_out_u;

    systolic_array_stream #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C), .K_WIDTH(KW), .SIGNED(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .ifm_in(ifm_in), .wgt_in(wgt_in),
        .out_valid(out_valid), .out_ready(out_ready), .ofm_out(ofm_out),
        .out_last(out_last), .busy(busy), .done(done)
    );

    systolic_array_stream #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C), .K_WIDTH(KW), .SIGNED(0)
    ) u_dut_u (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready_u), .ifm_in(ifm_in), .wgt_in(wgt_in),
        .out_valid(out_valid_u), .out_ready(out_ready), .ofm_out(ofm_out_u),
        .out_last(out_last_u), .busy(busy_u), .done(done_u)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] ifm_mem [256][R];
    logic [DW-1:0] wgt_mem [256][C];
    longint        exp_s [R][C];
    longint        exp_u [R][C];

    typedef struct {
        int          k;
        logic [7:0]  ifm;
        logic [7:0]  wgt;
        int          gap;
        int          stall0;
        longint      exp_sv;
        longint      exp_uv;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: each output is a plain dot product over the k beats, wrapped to AW bits.
    task automatic model(input int k);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                longint s = 0;
                longint u = 0;
                for (int b = 0; b < k; b++) begin
                    s += longint'($signed(ifm_mem[b][r])) * longint'($signed(wgt_mem[b][c]));
                    u += longint'(ifm_mem[b][r]) * longint'(wgt_mem[b][c]);
                end
                exp_s[r][c] = s & longint'((1 << AW) - 1);
                exp_u[r][c] = u & longint'((1 << AW) - 1);
            end
        end
    endtask

    task automatic check_lanes(input string tag, input int c);
        for (int r = 0; r < R; r++) begin
            check($sformatf("%s_s_b%0d_r%0d", tag, c, r), longint'(ofm_out[r*AW +: AW]), exp_s[r][c]);
            check($sformatf("%s_u_b%0d_r%0d", tag, c, r), longint'(ofm_out_u[r*AW +: AW]), exp_u[r][c]);
        end
    endtask

    task automatic run(input int k, input int gap, input int stall0, input bit rnd,
                       input bit start_in_drain, input string tag);
        int cnt;
        int st;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        @(negedge clk);
        start = 1'b0;
        k_len = '0;
        check({tag, "_busy_load"}, busy, 1);
        for (int b = 0; b < k; b++) begin
            int g;
            g = rnd ? int'($urandom_range(0, 2)) : gap;
            for (int i = 0; i < g; i++) begin
                in_valid = 1'b0;
                check($sformatf("%s_ready_gap%0d", tag, b), in_ready, 1);
                @(negedge clk);
            end
            in_valid = 1'b1;
            for (int r = 0; r < R; r++) ifm_in[r*DW +: DW] = ifm_mem[b][r];
            for (int c = 0; c < C; c++) wgt_in[c*DW +: DW] = wgt_mem[b][c];
            check($sformatf("%s_ready_beat%0d", tag, b), in_ready, 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = (stall0 == 0);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_flush_len"}, cnt, R + C - 1);
        for (int c = 0; c < C; c++) begin
            st = (c == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int i = 0; i < st; i++) begin
                out_ready = 1'b0;
                check($sformatf("%s_hold_valid_b%0d", tag, c), out_valid, 1);
                check_lanes({tag, "_hold"}, c);
                @(negedge clk);
            end
            out_ready = 1'b1;
            check($sformatf("%s_valid_b%0d", tag, c), out_valid, 1);
            check($sformatf("%s_last_b%0d", tag, c), {out_last, out_last_u}, (c == C - 1) ? 3 : 0);
            check_lanes(tag, c);
            if (start_in_drain && c == 1) begin
                start = 1'b1;
                k_len = KW'(3);
            end
            @(negedge clk);
            start = 1'b0;
            k_len = '0;
        end
        check({tag, "_done"}, {done, done_u}, 3);
        check({tag, "_busy_end"}, {busy, busy_u}, 0);
        check({tag, "_ofm_zero"}, longint'(|{ofm_out, ofm_out_u, out_valid}), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, done_u, busy}, 0);
        $display("[TB] run %s k=%0d done", tag, k);
    endtask

    task automatic fill_uniform(input int k, input logic [7:0] iv, input logic [7:0] wv);
        for (int b = 0; b < k; b++) begin
            for (int r = 0; r < R; r++) ifm_mem[b][r] = iv;
            for (int c = 0; c < C; c++) wgt_mem[b][c] = wv;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ifm_in    = '0;
        wgt_in    = '0;

        vecs[0] = '{3,  8'd1,   8'd2,   0, 0, 64'd6,      64'd6};
        vecs[1] = '{2,  8'hFD,  8'd5,   0, 0, 64'hFFFE2,  64'd2530};
        vecs[2] = '{3,  8'd1,   8'd2,   2, 0, 64'd6,      64'd6};
        vecs[3] = '{66, 8'd127, 8'd127, 0, 3, 64'h03E42,  64'h03E42};

        repeat (3) @(negedge clk);
        check("rst_outputs", longint'({in_ready, out_valid, out_last, busy, done}), 0);
        check("rst_ofm", longint'(|{ofm_out, ofm_out_u}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            fill_uniform(vecs[v].k, vecs[v].ifm, vecs[v].wgt);
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    exp_s[r][c] = vecs[v].exp_sv;
                    exp_u[r][c] = vecs[v].exp_uv;
                end
            end
            run(vecs[v].k, vecs[v].gap, vecs[v].stall0, 1'b0, 1'b0, $sformatf("vec%0d", v));
        end

        // Skew check: distinct row/column operands, drain stalled at beat 0.
        for (int r = 0; r < R; r++) ifm_mem[0][r] = DW'(r + 1);
        for (int c = 0; c < C; c++) wgt_mem[0][c] = DW'(c + 1);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                exp_s[r][c] = longint'((r + 1) * (c + 1));
                exp_u[r][c] = longint'((r + 1) * (c + 1));
            end
        run(1, 0, 5, 1'b0, 1'b0, "skew");

        // Reset in the middle of LOAD abandons the run with no done.
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(5);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        ifm_in   = {R{8'h55}};
        wgt_in   = {C{8'h33}};
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs", longint'({in_ready, out_valid, out_last, busy, done}), 0);
        check("midrst_ofm", longint'(|{ofm_out, ofm_out_u}), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("midrst_no_done", seen, 0);
        end
        fill_uniform(3, 8'd1, 8'd2);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                exp_s[r][c] = 6;
                exp_u[r][c] = 6;
            end
        run(3, 0, 0, 1'b0, 1'b0, "after_rst");

        // start with k_len=0 is ignored.
        @(negedge clk);
        start = 1'b1;
        k_len = '0;
        @(negedge clk);
        start = 1'b0;
        check("klen0_busy", {busy, busy_u}, 0);
        @(negedge clk);
        check("klen0_idle", {busy, done, in_ready}, 0);

        // Randomized runs against the model; one also pulses start during DRAIN.
        for (int t = 0; t < 8; t++) begin
            int k;
            k = int'($urandom_range(1, 12));
            for (int b = 0; b < k; b++) begin
                for (int r = 0; r < R; r++) ifm_mem[b][r] = DW'($urandom);
                for (int c = 0; c < C; c++) wgt_mem[b][c] = DW'($urandom);
            end
            model(k);
            run(k, 0, int'($urandom_range(0, 3)), 1'b1, (t == 2), $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
